// File: rtl/dcache_rd_resp_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the data-cache read responder:
//   - default configuration (LINES_DEFAULT) and derived index/tag widths
//   - FSM state encoding
//   - index/tag width helper types for the default configuration
//   - helper to turn a byte address into a word address
// ----------------------------------------------------------------------------
package cache_pkg;

    // Number of one-word cache lines in the default configuration.
    localparam int LINES_DEFAULT = 16;
    localparam int IDX_W_DEFAULT = $clog2(LINES_DEFAULT);
    localparam int TAG_W_DEFAULT = 30 - IDX_W_DEFAULT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic [IDX_W_DEFAULT-1:0] index_t;
    typedef logic [TAG_W_DEFAULT-1:0] tag_t;

    // Byte address -> word address (drops the byte offset).
    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dcache_rd_resp_if.sv
// ----------------------------------------------------------------------------
// dcache_rd_resp_if
// Bundles the pipeline-side load/store signals and the backing-memory
// read handshake of the data-cache read responder.
//   slave  : the cache (drives rdata/valid/hit/stall and mem_req/mem_addr)
//   master : pipeline + memory side (drives request, store, flush, mem ack)
// ----------------------------------------------------------------------------
interface dcache_rd_resp_if;

    // pipeline MEM stage
    logic        rd_request_i;
    logic [31:0] addr_i;
    logic        wr_en_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic [31:0] rdata_o;
    logic        valid_o;
    logic        hit_o;
    logic        stall_o;

    // backing memory
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  rd_request_i, addr_i, wr_en_i, wdata_i, flush_i,
        input  mem_ack_i, mem_rdata_i,
        output rdata_o, valid_o, hit_o, stall_o,
        output mem_req_o, mem_addr_o
    );

    modport master (
        output rd_request_i, addr_i, wr_en_i, wdata_i, flush_i,
        output mem_ack_i, mem_rdata_i,
        input  rdata_o, valid_o, hit_o, stall_o,
        input  mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/dcache_rd_resp_tag_array.sv
// ----------------------------------------------------------------------------
// dcache_tag_array
// Valid/tag/data storage for a direct-mapped cache of one-word lines.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears valid bits)
//   flush_i       : clears every valid bit; wins over a same-cycle write
//   rd_idx_i      : combinational read index -> rd_valid_o/rd_tag_o/rd_data_o
//   we_i, wr_*    : single write port; a write always sets the line valid
// ----------------------------------------------------------------------------
module dcache_tag_array #(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [LINES-1:0] valid_vec;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // Each valid bit is its own flop so it can be cleared asynchronously
    // by reset and in bulk by flush, independently of the tag/data arrays.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            logic valid_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_reg <= 1'b0;
                end else if (flush_i) begin
                    valid_reg <= 1'b0;
                end else if (we_i && (wr_idx_i == IDX_W'(gi))) begin
                    valid_reg <= 1'b1;
                end
            end
            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

    // Tag/data contents are meaningless while the valid bit is clear,
    // so they need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_vec[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/dcache_rd_resp.sv
// ----------------------------------------------------------------------------
// dcache_rd_resp
// Data-side read responder backed by a direct-mapped, write-through cache.
// Hits answer in the request cycle; misses stall, fetch one word over the
// mem_req/mem_ack handshake, install it and return it in a one-cycle RESP.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : load/store/flush from MEM stage, rdata/valid/hit/stall
//                   back to the pipeline, mem_req/mem_addr/mem_ack/mem_rdata
//                   to the backing memory
// ----------------------------------------------------------------------------
module dcache_rd_resp
    import cache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dcache_rd_resp_if.slave  bus
);

    localparam int TAG_W = 30 - IDX_W;

    state_t state_reg, state_next;

    logic [29:0]      miss_addr_reg;   // word address of the outstanding miss
    logic [31:0]      resp_data_reg;
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             line_hit, load_hit, load_miss, store_hit, install;
    logic             we;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [31:0]      wr_data;
    logic             unused_addr_bits;

    assign rd_idx           = bus.addr_i[IDX_W+1:2];
    assign rd_tag           = bus.addr_i[31:IDX_W+2];
    assign unused_addr_bits = ^bus.addr_i[1:0];

    assign line_hit  = line_valid && (line_tag == rd_tag);
    assign load_hit  = (state_reg == IDLE) && bus.rd_request_i && line_hit;
    assign load_miss = (state_reg == IDLE) && bus.rd_request_i && !line_hit;
    // A store shares the MEM stage with a load, so a same-cycle load wins.
    assign store_hit = (state_reg == IDLE) && bus.wr_en_i && !bus.rd_request_i && line_hit;
    assign install   = (state_reg == REFILL) && bus.mem_ack_i;

    // Install and store are exclusive by state, so one write port suffices.
    assign we      = install || store_hit;
    assign wr_idx  = install ? miss_addr_reg[IDX_W-1:0] : rd_idx;
    assign wr_tag  = install ? miss_addr_reg[29:IDX_W]  : rd_tag;
    assign wr_data = install ? bus.mem_rdata_i          : bus.wdata_i;

    dcache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (bus.flush_i),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .we_i       (we),
        .wr_idx_i   (wr_idx),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (wr_data)
    );

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
            resp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_miss) begin
                miss_addr_reg <= word_addr(bus.addr_i);
            end
            if (install) begin
                resp_data_reg <= bus.mem_rdata_i;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_miss) state_next = REFILL;
            REFILL:  if (bus.mem_ack_i) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic. Gated by rst_ni so that a held request cannot raise
    // stall while the block sits in reset.
    always_comb begin
        bus.rdata_o    = '0;
        bus.valid_o    = 1'b0;
        bus.hit_o      = 1'b0;
        bus.stall_o    = 1'b0;
        bus.mem_req_o  = 1'b0;
        bus.mem_addr_o = '0;
        if (rst_ni) begin
            case (state_reg)
                IDLE: begin
                    bus.valid_o = load_hit;
                    bus.hit_o   = load_hit;
                    bus.rdata_o = load_hit ? line_data : '0;
                    bus.stall_o = load_miss;
                end
                REFILL: begin
                    bus.mem_req_o  = 1'b1;
                    bus.mem_addr_o = {miss_addr_reg, 2'b00};
                    bus.stall_o    = 1'b1;
                end
                RESP: begin
                    bus.valid_o = 1'b1;
                    bus.rdata_o = resp_data_reg;
                end
                default: ;
            endcase
        end
    end

endmodule
